// File: rtl/app_reg_if.sv
// ============================================================================
// Module : app_reg_if
// Brief  : Register bundle between the register host and the device consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface app_reg_if;
    logic [7:0]  base_wr;
    logic [15:0] example_wr;
    logic [7:0]  base_rd;
    logic [15:0] example_rd;

    modport host (
        output base_wr,
        output example_wr,
        input  base_rd,
        input  example_rd
    );

    modport device (
        input  base_wr,
        input  example_wr,
        output base_rd,
        output example_rd
    );
endinterface

`default_nettype wire

// File: rtl/app_reg_host.sv
// ============================================================================
// Module : app_reg_host
// Brief  : Single-outstanding register host: valid/ready request in, drives
//          app_reg_if host side, samples readback after a settle delay.
//          Optional macro APP_REG_HOST_ERR_EN flags writes to read-only addrs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module app_reg_host #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        req_valid,
    output logic             req_ready,
    input  wire logic        req_write,
    input  wire logic [1:0]  req_addr,
    input  wire logic [15:0] req_wdata,
    output logic             rsp_valid,
    input  wire logic        rsp_ready,
    output logic [15:0]      rsp_rdata,
    output logic             rsp_err,
    app_reg_if.host          regs
);

    localparam int c_cnt_w = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_settle  = c_cnt_w'(SETTLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [1:0]           r_addr;
    logic [7:0]           r_base_wr;
    logic [15:0]          r_example_wr;
    logic [15:0]          r_rsp_rdata;
    logic [15:0]          w_rdback;
    logic                 w_req_fire;
    logic                 w_settle_done;

    assign req_ready     = (r_state == S_IDLE) && !rst;
    assign w_req_fire    = req_valid && req_ready;
    assign w_settle_done = (r_state == S_SETTLE) && (r_cnt == '0);
    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_rdata     = r_rsp_rdata;

    assign regs.base_wr    = r_base_wr;
    assign regs.example_wr = r_example_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req_fire)    w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == '0)   w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready)     w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    // Readback of the latched address; writes have already landed by now.
    always_comb begin
        w_rdback = 16'h0000;
        case (r_addr)
            2'd0:    w_rdback = {8'h00, r_base_wr};
            2'd1:    w_rdback = r_example_wr;
            2'd2:    w_rdback = {8'h00, regs.base_rd};
            default: w_rdback = regs.example_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_addr       <= 2'd0;
            r_base_wr    <= 8'h00;
            r_example_wr <= 16'h0000;
            r_rsp_rdata  <= 16'h0000;
        end else begin
            if (w_req_fire) begin
                r_addr <= req_addr;
                r_cnt  <= c_settle;
                if (req_write) begin
                    case (req_addr)
                        2'd0:    r_base_wr    <= req_wdata[7:0];
                        2'd1:    r_example_wr <= req_wdata;
                        default: ;
                    endcase
                end
            end else if (r_state == S_SETTLE) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_cnt_one;
                end else begin
                    r_rsp_rdata <= w_rdback;
                end
            end
        end
    end

`ifdef APP_REG_HOST_ERR_EN
    logic r_write;
    logic r_rsp_err;

    // Addresses 2 and 3 are read-only; a write there is reported, not applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write   <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_write <= req_write;
            end
            if (w_settle_done) begin
                r_rsp_err <= r_write && r_addr[1];
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_app_reg_host.sv
// ============================================================================
// Module : tb_app_reg_host
// Brief  : Self-checking bench for app_reg_host with an rd = wr+1 consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_app_reg_host;

    localparam int SETTLE = 2;
`ifdef APP_REG_HOST_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    app_reg_if regs ();

    // Downstream consumer: readback is write value plus one.
    assign regs.base_rd    = regs.base_wr + 8'd1;
    assign regs.example_rd = regs.example_wr + 16'd1;

    app_reg_host #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .regs      (regs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_base = 8'h00;
    logic [15:0] m_ex   = 16'h0000;
    bit          pend   = 1'b0;
    int          acc    = 0;
    logic [15:0] e_rd   = 16'h0000;
    logic        e_err  = 1'b0;
    bit          e_valid;

    function automatic logic [15:0] readback(input logic [1:0] a);
        logic [7:0]  b1;
        logic [15:0] e1;
        b1 = m_base + 8'd1;
        e1 = m_ex + 16'd1;
        case (a)
            2'd0:    return {8'h00, m_base};
            2'd1:    return m_ex;
            2'd2:    return {8'h00, b1};
            default: return e1;
        endcase
    endfunction

    always @(negedge clk) begin
        e_valid = pend && (cyc >= acc + SETTLE + 1);
        if (cyc >= 1) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !rst && !pend});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
            chk("base_wr",   {24'd0, regs.base_wr}, {24'd0, m_base});
            chk("example_wr", {16'd0, regs.example_wr}, {16'd0, m_ex});
            if (e_valid) begin
                chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e_rd});
                chk("rsp_err",   {31'd0, rsp_err},   {31'd0, e_err});
            end
        end
        // Predict the effect of the upcoming rising edge.
        if (rst) begin
            pend   = 1'b0;
            m_base = 8'h00;
            m_ex   = 16'h0000;
        end else if (req_valid && !pend) begin
            if (req_write && req_addr == 2'd0) m_base = req_wdata[7:0];
            if (req_write && req_addr == 2'd1) m_ex   = req_wdata;
            e_rd  = readback(req_addr);
            e_err = ERR_EN && req_write && req_addr[1];
            pend  = 1'b1;
            acc   = cyc + 1;
        end else if (e_valid && rsp_ready) begin
            pend = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input bit wr, input logic [1:0] a, input logic [15:0] d,
                       input int hold, input bit poke,
                       output logic [15:0] rd, output logic er);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 2'($urandom);
        req_wdata = 16'($urandom);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, SETTLE + 1);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 2'd0;
                req_wdata = 16'hFFFF;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(1'b1, 2'd0, 16'h00AB, 0, 1'b0, rd, er);
        chk("wr0_rd", {16'd0, rd}, 32'h00AB);
        txn(1'b0, 2'd2, 16'h0000, 0, 1'b0, rd, er);
        chk("rd2_rd", {16'd0, rd}, 32'h00AC);
        chk("rd2_err", {31'd0, er}, 32'd0);

        txn(1'b1, 2'd1, 16'hCDEF, 1, 1'b0, rd, er);
        txn(1'b0, 2'd3, 16'h0000, 0, 1'b0, rd, er);
        chk("rd3_rd", {16'd0, rd}, 32'hCDF0);
        txn(1'b0, 2'd1, 16'h0000, 2, 1'b0, rd, er);
        chk("rd1_rd", {16'd0, rd}, 32'hCDEF);

        txn(1'b1, 2'd0, 16'h12FF, 0, 1'b0, rd, er);
        chk("wr0_trunc", {16'd0, rd}, 32'h00FF);
        txn(1'b0, 2'd0, 16'h0000, 0, 1'b0, rd, er);
        chk("rd0_trunc", {16'd0, rd}, 32'h00FF);
        txn(1'b0, 2'd2, 16'h0000, 0, 1'b0, rd, er);
        chk("rd2_wrap", {16'd0, rd}, 32'h0000);

        // Backpressure with a stray request pulse inside the window.
        txn(1'b0, 2'd1, 16'h0000, 5, 1'b1, rd, er);
        chk("bp_rd", {16'd0, rd}, 32'hCDEF);
        chk("bp_base", {24'd0, regs.base_wr}, 32'h00FF);

        txn(1'b1, 2'd2, 16'h0055, 0, 1'b0, rd, er);
        chk("ro_err", {31'd0, er}, {31'd0, ERR_EN});
        chk("ro_rd", {16'd0, rd}, 32'h0000);
        chk("ro_base", {24'd0, regs.base_wr}, 32'h00FF);

        // Reset during SETTLE aborts the transaction.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 16'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_wr", {16'd0, regs.example_wr}, 32'h1234);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ex", {16'd0, regs.example_wr}, 32'h0000);
        txn(1'b0, 2'd3, 16'h0000, 0, 1'b0, rd, er);
        chk("abort_rd3", {16'd0, rd}, 32'h0001);

        for (int k = 0; k < 60; k++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                $urandom_range(0, 3), ($urandom_range(0, 3) == 0), rd, er);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
